// File: rtl/stopwatch_ctrl.sv
// Pushbutton front end for the BCD stopwatch: synchronize, debounce, arbitrate
// press events and sequence the datapath control inputs through a mode FSM.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic       clk_in,
  input  logic       RST,
  input  logic       BTN_START,
  input  logic       BTN_RESET,
  input  logic       BTN_REV,
  input  logic       BTN_ADD,
  input  logic       BTN_SUB,
  input  logic       BTN_FAST,
  input  logic       BTN_SLOW,
  input  logic       AT_LIMIT,
  output logic       START,
  output logic       REVERSE,
  output logic       RESET,
  output logic       ADD,
  output logic       SUBTRACT,
  output logic       SPEED_UP,
  output logic       SPEED_DOWN,
  output logic [2:0] STATE
);

  localparam int unsigned NB = 7;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // Bit index doubles as priority: lower index wins.
  localparam int unsigned I_RESET = 0;
  localparam int unsigned I_REV   = 1;
  localparam int unsigned I_ADD   = 2;
  localparam int unsigned I_SUB   = 3;
  localparam int unsigned I_START = 4;
  localparam int unsigned I_FAST  = 5;
  localparam int unsigned I_SLOW  = 6;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_RUN     = 3'd3,
    ST_LIMIT   = 3'd4,
    ST_REVLOAD = 3'd5
  } state_t;

  logic [NB-1:0] raw, sync1, sync2, deb, deb_d, ev, win;
  logic [DW-1:0] db_cnt [NB];

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic          start_nxt, reverse_nxt, reset_nxt, add_nxt, sub_nxt;
  logic          up_nxt, down_nxt;

  assign raw = {BTN_SLOW, BTN_FAST, BTN_START, BTN_SUB, BTN_ADD, BTN_REV, BTN_RESET};

  // Synchronizer and per-button disagreement counter.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising edges only; isolating the lowest set bit picks the priority winner.
  assign ev  = deb & ~deb_d;
  assign win = ev & (~ev + NB'(1));

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      state      <= ST_INIT;
      settle_cnt <= '0;
      START      <= 1'b0;
      REVERSE    <= 1'b0;
      RESET      <= 1'b0;
      ADD        <= 1'b0;
      SUBTRACT   <= 1'b0;
      SPEED_UP   <= 1'b0;
      SPEED_DOWN <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      START      <= start_nxt;
      REVERSE    <= reverse_nxt;
      RESET      <= reset_nxt;
      ADD        <= add_nxt;
      SUBTRACT   <= sub_nxt;
      SPEED_UP   <= up_nxt;
      SPEED_DOWN <= down_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    settle_nxt  = '0;
    reverse_nxt = REVERSE;
    reset_nxt   = 1'b0;
    add_nxt     = 1'b0;
    sub_nxt     = 1'b0;
    up_nxt      = SPEED_UP;
    down_nxt    = SPEED_DOWN;

    case (state)
      ST_INIT: begin
        reset_nxt = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_nxt = ST_PAUSE;
        else settle_nxt = settle_cnt + SW'(1);
      end
      ST_PAUSE: begin
        if (win[I_RESET]) begin
          reset_nxt = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (win[I_REV]) begin
          reverse_nxt = ~REVERSE;
          state_nxt   = ST_REVLOAD;
        end else if (win[I_ADD]) begin
          add_nxt   = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (win[I_SUB]) begin
          sub_nxt   = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (win[I_START] && !AT_LIMIT) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (win[I_RESET]) begin
          reset_nxt = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (AT_LIMIT) begin
          state_nxt = ST_LIMIT;
        end else if (win[I_START]) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_LIMIT: begin
        if (win[I_RESET]) begin
          reset_nxt = 1'b1;
          state_nxt = ST_SETTLE;
        end else if (win[I_REV]) begin
          reverse_nxt = ~REVERSE;
          state_nxt   = ST_REVLOAD;
        end else if (win[I_SUB]) begin
          sub_nxt   = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_REVLOAD: begin
        reset_nxt = 1'b1;
        state_nxt = ST_SETTLE;
      end
      default: state_nxt = ST_INIT;
    endcase

    // Speed level lives in the two outputs: neither set means NORMAL.
    if (state == ST_PAUSE || state == ST_RUN || state == ST_LIMIT) begin
      if (win[I_FAST]) begin
        if (SPEED_DOWN) down_nxt = 1'b0;
        else up_nxt = 1'b1;
      end else if (win[I_SLOW]) begin
        if (SPEED_UP) up_nxt = 1'b0;
        else down_nxt = 1'b1;
      end
    end

    start_nxt = (state_nxt == ST_RUN);
  end

  assign STATE = 3'(state);

endmodule
